// File: rtl/jpeg_ac_dc_sequencer.sv
// JPEG entropy-coding sequencer: turns one 64-coefficient zigzag block into DC/AC
// run-size symbols (with ZRL and EOB insertion) behind a single output register.

module coefficient_encoder (
  input  logic [15:0] value,
  output logic [15:0] coded_value,
  output logic [3:0]  coded_value_length
);

  logic [15:0] magnitude_s;
  logic [15:0] mask_s;
  logic [15:0] adjusted_s;

  // Magnitude category is the position of the highest set bit of |value|.
  always_comb begin
    magnitude_s = 16'h0000;
    if (value[15]) begin
      magnitude_s = 16'h0000 - value;
    end else begin
      magnitude_s = value;
    end
    coded_value_length = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (magnitude_s[i]) begin
        coded_value_length = 4'(i + 1);
      end else begin
        coded_value_length = coded_value_length;
      end
    end
  end

  // Negative values are sent as the low bits of value-1; zero masks to nothing.
  always_comb begin
    adjusted_s = 16'h0000;
    if (value[15]) begin
      adjusted_s = value - 16'h0001;
    end else begin
      adjusted_s = value;
    end
    mask_s      = (16'h0001 << coded_value_length) - 16'h0001;
    coded_value = adjusted_s & mask_s;
  end

endmodule

module jpeg_ac_dc_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        dc_predictor_reset,
  input  logic [15:0] in_coefficient,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_rs,
  output logic [15:0] out_coded_value,
  output logic [3:0]  out_coded_length,
  output logic        out_is_dc,
  output logic        out_block_last,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [0:0] {ACCEPT = 1'b0, ZRL = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [5:0]  idx_r, idx_s;
  logic [5:0]  run_r, run_s;
  logic [15:0] pred_r, pred_s;
  logic [15:0] hold_r, hold_s;

  logic        slot_free_s;
  logic        accept_s;
  logic [15:0] diff_s;
  logic [15:0] operand_s;
  logic [15:0] enc_value_s;
  logic [3:0]  enc_length_s;

  logic        load_s;
  logic [7:0]  rs_s;
  logic [15:0] value_s;
  logic [3:0]  length_s;
  logic        is_dc_s;
  logic        last_s;

  assign slot_free_s = !out_valid || out_ready;
  assign in_ready    = (state_r == ACCEPT) && slot_free_s;
  assign accept_s    = in_valid && in_ready;
  assign diff_s      = in_coefficient - (dc_predictor_reset ? 16'h0000 : pred_r);

  // Select what the shared encoder sees: held AC, DC difference, or live AC.
  always_comb begin
    operand_s = in_coefficient;
    if (state_r == ZRL) begin
      operand_s = hold_r;
    end else if (idx_r == 6'd0) begin
      operand_s = diff_s;
    end else begin
      operand_s = in_coefficient;
    end
  end

  coefficient_encoder u_encoder (
    .value              (operand_s),
    .coded_value        (enc_value_s),
    .coded_value_length (enc_length_s)
  );

  // Next-state, counters and symbol to load into the output register.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    run_s    = run_r;
    pred_s   = pred_r;
    hold_s   = hold_r;
    load_s   = 1'b0;
    rs_s     = 8'h00;
    value_s  = 16'h0000;
    length_s = 4'd0;
    is_dc_s  = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ACCEPT: begin
        if (accept_s) begin
          if (idx_r == 6'd0) begin
            load_s   = 1'b1;
            rs_s     = {4'h0, enc_length_s};
            value_s  = enc_value_s;
            length_s = enc_length_s;
            is_dc_s  = 1'b1;
            pred_s   = in_coefficient;
            run_s    = 6'd0;
            idx_s    = 6'd1;
          end else if (in_coefficient == 16'h0000) begin
            if (idx_r == 6'd63) begin
              // Trailing zeros collapse into a single EOB.
              load_s = 1'b1;
              last_s = 1'b1;
              run_s  = 6'd0;
              idx_s  = 6'd0;
            end else begin
              run_s = run_r + 6'd1;
              idx_s = idx_r + 6'd1;
            end
          end else if (run_r < 6'd16) begin
            load_s   = 1'b1;
            rs_s     = {run_r[3:0], enc_length_s};
            value_s  = enc_value_s;
            length_s = enc_length_s;
            last_s   = (idx_r == 6'd63);
            run_s    = 6'd0;
            idx_s    = idx_r + 6'd1;
          end else begin
            load_s  = 1'b1;
            rs_s    = 8'hF0;
            run_s   = run_r - 6'd16;
            hold_s  = in_coefficient;
            state_s = ZRL;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      ZRL: begin
        if (slot_free_s) begin
          if (run_r >= 6'd16) begin
            load_s = 1'b1;
            rs_s   = 8'hF0;
            run_s  = run_r - 6'd16;
          end else begin
            load_s   = 1'b1;
            rs_s     = {run_r[3:0], enc_length_s};
            value_s  = enc_value_s;
            length_s = enc_length_s;
            last_s   = (idx_r == 6'd63);
            run_s    = 6'd0;
            idx_s    = idx_r + 6'd1;
            state_s  = ACCEPT;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_s = ACCEPT;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ACCEPT;
      idx_r   <= 6'd0;
      run_r   <= 6'd0;
      pred_r  <= 16'h0000;
      hold_r  <= 16'h0000;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      run_r   <= run_s;
      pred_r  <= pred_s;
      hold_r  <= hold_s;
    end
  end

  // Output slot: load wins over drain so back-to-back symbols need no bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid        <= 1'b0;
      out_rs           <= 8'h00;
      out_coded_value  <= 16'h0000;
      out_coded_length <= 4'd0;
      out_is_dc        <= 1'b0;
      out_block_last   <= 1'b0;
    end else if (load_s) begin
      out_valid        <= 1'b1;
      out_rs           <= rs_s;
      out_coded_value  <= value_s;
      out_coded_length <= length_s;
      out_is_dc        <= is_dc_s;
      out_block_last   <= last_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_jpeg_ac_dc_sequencer.sv
// Directed bench for jpeg_ac_dc_sequencer: hand-computed symbols plus a block-level reference model.
module tb_jpeg_ac_dc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        dc_predictor_reset;
  logic [15:0] in_coefficient;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_rs;
  logic [15:0] out_coded_value;
  logic [3:0]  out_coded_length;
  logic        out_is_dc;
  logic        out_block_last;
  logic        out_valid;
  logic        out_ready;

  jpeg_ac_dc_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .dc_predictor_reset (dc_predictor_reset),
    .in_coefficient     (in_coefficient),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .out_rs             (out_rs),
    .out_coded_value    (out_coded_value),
    .out_coded_length   (out_coded_length),
    .out_is_dc          (out_is_dc),
    .out_block_last     (out_block_last),
    .out_valid          (out_valid),
    .out_ready          (out_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  logic signed [15:0] blk [64];
  logic signed [15:0] model_pred = 16'sd0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];

  // Record transfers and count cycles where input side is blocked.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready)
      got_q.push_back({2'b00, out_is_dc, out_block_last, out_rs, out_coded_length, out_coded_value});
    if (!reset && !in_ready)
      stall_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sym(input logic dc, input logic last, input logic [7:0] rs,
                                      input logic [3:0] len, input logic [15:0] val);
    return {2'b00, dc, last, rs, len, val};
  endfunction

  function automatic logic [3:0] cat(input logic signed [15:0] v);
    int m;
    int n;
    m = (v < 0) ? -int'(v) : int'(v);
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    return n[3:0];
  endfunction

  function automatic logic [15:0] mval(input logic signed [15:0] v);
    int t;
    int n;
    n = int'(cat(v));
    t = (v < 0) ? int'(v) - 1 : int'(v);
    t = t & ((1 << n) - 1);
    return t[15:0];
  endfunction

  task automatic model_block(input logic dcr);
    logic signed [15:0] d;
    int run;
    d = blk[0] - (dcr ? 16'sd0 : model_pred);
    model_pred = blk[0];
    exp_q.push_back(sym(1'b1, 1'b0, {4'h0, cat(d)}, cat(d), mval(d)));
    run = 0;
    for (int i = 1; i < 64; i++) begin
      if (blk[i] == 16'sd0) begin
        run++;
        if (i == 63) exp_q.push_back(sym(1'b0, 1'b1, 8'h00, 4'd0, 16'h0000));
      end else begin
        while (run >= 16) begin
          exp_q.push_back(sym(1'b0, 1'b0, 8'hF0, 4'd0, 16'h0000));
          run -= 16;
        end
        exp_q.push_back(sym(1'b0, (i == 63), {4'(run), cat(blk[i])}, cat(blk[i]), mval(blk[i])));
        run = 0;
      end
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_sym%0d", tag, i), got_q[i], exp_q[i]);
      else check($sformatf("%s_missing%0d", tag, i), 32'hFFFF_FFFF, exp_q[i]);
    end
  endtask

  task automatic got_at(input int i, output logic [31:0] w);
    if (i < got_q.size()) w = got_q[i];
    else w = 32'hFFFF_FFFF;
  endtask

  task automatic send_coef(input logic [15:0] c);
    int budget;
    logic r;
    budget = 100;
    r = 1'b0;
    in_coefficient = c;
    in_valid = 1'b1;
    while (!r && budget > 0) begin
      @(negedge clock);
      r = in_ready;
      budget--;
      @(posedge clock);
      #1;
    end
    if (!r) check("accept_timeout", 32'(r), 32'd1);
  endtask

  task automatic send_range(input int first, input int last, input logic dcr);
    for (int i = first; i <= last; i++) begin
      dc_predictor_reset = (i == 0) ? dcr : 1'b0;
      send_coef(blk[i]);
    end
    dc_predictor_reset = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 50;
    in_valid = 1'b0;
    @(negedge clock);
    while (out_valid && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("drain_timeout", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
    stall_cycles = 0;
    for (int i = 0; i < 64; i++) blk[i] = 16'sd0;
  endtask

  logic [31:0] w;

  initial begin
    reset = 1'b1;
    dc_predictor_reset = 1'b0;
    in_coefficient = 16'h0000;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rs", 32'(out_rs), 32'd0);
    check("rst_out_value", 32'(out_coded_value), 32'd0);
    check("rst_out_length", 32'(out_coded_length), 32'd0);
    check("rst_out_is_dc", 32'(out_is_dc), 32'd0);
    check("rst_out_last", 32'(out_block_last), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Block [5, 0x63]
    start_test();
    blk[0] = 16'sd5;
    send_range(0, 63, 1'b0);
    wait_drain();
    got_at(0, w); check("t1_dc", w, sym(1'b1, 1'b0, 8'h03, 4'd3, 16'd5));
    got_at(1, w); check("t1_eob", w, sym(1'b0, 1'b1, 8'h00, 4'd0, 16'd0));
    check("t1_stalls", 32'(stall_cycles), 32'd0);
    model_block(1'b0);
    compare_stream("t1");

    // Block [3, 0x63]: diff -2 against predictor 5
    start_test();
    blk[0] = 16'sd3;
    send_range(0, 63, 1'b0);
    wait_drain();
    got_at(0, w); check("t2_dc", w, sym(1'b1, 1'b0, 8'h02, 4'd2, 16'd1));
    model_block(1'b0);
    compare_stream("t2");

    // Same block with the predictor cleared
    start_test();
    blk[0] = 16'sd3;
    send_range(0, 63, 1'b1);
    wait_drain();
    got_at(0, w); check("t3_dc_pred_reset", w, sym(1'b1, 1'b0, 8'h02, 4'd2, 16'd3));
    model_block(1'b1);
    compare_stream("t3");

    // Run of 20 zeros before -1 at index 21: one ZRL then rs 0x41
    start_test();
    blk[21] = -16'sd1;
    send_range(0, 63, 1'b1);
    wait_drain();
    got_at(0, w); check("t4_dc", w, sym(1'b1, 1'b0, 8'h00, 4'd0, 16'd0));
    got_at(1, w); check("t4_zrl", w, sym(1'b0, 1'b0, 8'hF0, 4'd0, 16'd0));
    got_at(2, w); check("t4_ac", w, sym(1'b0, 1'b0, 8'h41, 4'd1, 16'd0));
    got_at(3, w); check("t4_eob", w, sym(1'b0, 1'b1, 8'h00, 4'd0, 16'd0));
    check("t4_count", 32'(got_q.size()), 32'd4);
    check("t4_stalls", 32'(stall_cycles), 32'd1);
    model_block(1'b1);

    // 7 at index 63 after 62 zeros: three ZRLs, last symbol, no EOB
    start_test();
    blk[63] = 16'sd7;
    send_range(0, 63, 1'b0);
    wait_drain();
    got_at(1, w); check("t5_zrl1", w, sym(1'b0, 1'b0, 8'hF0, 4'd0, 16'd0));
    got_at(3, w); check("t5_zrl3", w, sym(1'b0, 1'b0, 8'hF0, 4'd0, 16'd0));
    got_at(4, w); check("t5_last", w, sym(1'b0, 1'b1, 8'hE3, 4'd3, 16'd7));
    check("t5_count", 32'(got_q.size()), 32'd5);
    check("t5_stalls", 32'(stall_cycles), 32'd3);
    model_block(1'b0);
    compare_stream("t5");

    // Downstream backpressure for 10 cycles mid-block
    start_test();
    blk[0] = 16'sd100; blk[1] = -16'sd5; blk[5] = 16'sd20; blk[9] = -16'sd300;
    blk[30] = 16'sd1; blk[50] = 16'sd2000; blk[62] = -16'sd1;
    send_range(0, 9, 1'b0);
    out_ready = 1'b0;
    in_coefficient = blk[10];
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check($sformatf("t6_frozen_rs%0d", k), 32'(out_rs), 32'h39);
      check($sformatf("t6_frozen_val%0d", k), 32'(out_coded_value), 32'h00D3);
      check($sformatf("t6_in_ready%0d", k), 32'(in_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    check("t6_frozen_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send_range(10, 63, 1'b0);
    wait_drain();
    model_block(1'b0);
    compare_stream("t6");

    // Asynchronous reset while ZRLs are pending
    start_test();
    blk[63] = 16'sd7;
    send_range(0, 63, 1'b0);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("t7_valid_drop", 32'(out_valid), 32'd0);
    check("t7_rs_clear", 32'(out_rs), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_pred = 16'sd0;
    @(posedge clock);
    #1;

    // Fresh block after reset uses predictor 0
    start_test();
    blk[0] = 16'sd4;
    send_range(0, 63, 1'b0);
    wait_drain();
    got_at(0, w); check("t8_dc", w, sym(1'b1, 1'b0, 8'h03, 4'd3, 16'd4));
    got_at(1, w); check("t8_eob", w, sym(1'b0, 1'b1, 8'h00, 4'd0, 16'd0));
    model_block(1'b0);
    compare_stream("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jpeg_ac_dc_sequencer.md
# jpeg_ac_dc_sequencer

Sequences one 8x8 block of quantized, zigzag-ordered coefficients through a `coefficient_encoder` instance and emits JPEG entropy-coding symbols to the downstream Huffman stage. It sits between the quantizer/zigzag buffer and the Huffman encoder. It performs these functions:
- DC differential prediction.
- AC zero-run counting.
- ZRL (16-zero) and EOB insertion.
- Ready/valid flow control on both sides.

## Interface
Parameters: none. Block size is fixed at 64 coefficients.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dc_predictor_reset` in 1: clears the DC predictor to 0. Sampled only at a block boundary (index 0, state ACCEPT); ignored otherwise.
- `in_coefficient` in 16: signed coefficient, zigzag order.
- `in_valid` in 1: upstream has a coefficient.
- `in_ready` out 1: sequencer accepts this cycle. Combinational.
- `out_rs` out 8: symbol byte, {run[3:0], size[3:0]}. For DC symbols, run = 0 and size = DC category.
- `out_coded_value` out 16: magnitude bits from `coefficient_encoder`; 0 when size = 0.
- `out_coded_length` out 4: bit count of `out_coded_value`, 0..15.
- `out_is_dc` out 1: symbol is the DC term.
- `out_block_last` out 1: final symbol of the block.
- `out_valid` out 1: output register holds a symbol.
- `out_ready` in 1: downstream consumes the symbol.

## Operation
- Single output register. A transfer occurs when `out_valid && out_ready`. The slot is "free" when `!out_valid || out_ready`.
- Internal state:
  - coefficient index `idx`, 6-bit, wraps 63→0.
  - zero-run counter `run`, 6-bit.
  - DC predictor `pred`, 16-bit signed.
  - held coefficient `hold`, 16-bit.
- FSM states: ACCEPT and ZRL.
- ACCEPT: `in_ready` = slot free. On `in_valid && in_ready`:
  - `idx`=0: diff = `in_coefficient` − (`dc_predictor_reset` ? 0 : `pred`), 16-bit wrap. Load the DC symbol with rs = {4'h0, size}. Set `pred` ← `in_coefficient` and `idx` ← 1.
  - `idx`>0, coefficient = 0: `run`++.
    - If `idx`=63: load EOB (rs 8'h00, length 0, last=1), then clear `run` and `idx`.
    - Otherwise `idx`++ and load nothing. `out_valid` falls if the slot drained.
  - `idx`>0, nonzero, `run` < 16: load rs = {run, size} with last = (`idx`=63). Clear `run`; `idx`++ with wrap.
  - `idx`>0, nonzero, `run` ≥ 16: load ZRL (rs 8'hF0, length 0). Set `run` −= 16, `hold` ← coefficient, and go to ZRL. `idx` does not advance yet.
- ZRL: `in_ready` = 0. When the slot is free:
  - If `run` ≥ 16, load another ZRL and set `run` −= 16.
  - Otherwise load {run, size(`hold`)} with last = (`idx`=63). Clear `run`, advance `idx`, return to ACCEPT.
- At most 3 ZRLs precede one symbol (run ≤ 62).
- Trailing zeros never produce ZRLs; only EOB. If coefficient 63 is nonzero, the block emits no EOB.
- Encoder arithmetic:
  - size = `coefficient_encoder` `coded_value_length` of the selected operand (DC diff, incoming AC, or `hold`).
  - Zero operand forces value 0 and length 0; never X.
- Caller guarantees |DC diff| ≤ 32767 and AC ≠ −32768.

## Timing
- Reset values:
  - `out_valid`=0; `out_rs`, `out_coded_value`, `out_coded_length`, `out_is_dc`, `out_block_last` all 0.
  - `idx`=0, `run`=0, `pred`=0; state ACCEPT.
  - `in_ready`=1 once reset deasserts.
- Latency: a coefficient accepted at edge N produces its symbol with `out_valid` from N+1. Each extra ZRL adds one cycle per free-slot cycle.
- Throughput: one coefficient per cycle with `out_ready` held 1, except one input stall cycle per ZRL.
- Output fields are stable while `out_valid && !out_ready`.
- Simultaneous drain and load in the same cycle is allowed (back-to-back symbols).
- Reset mid-block discards the partial block, the held coefficient and the pending symbol. The predictor clears.
- `dc_predictor_reset` asserted in the same cycle as the DC accept takes effect for that DC.

## Test plan
- Reset; block [5, 0×63] with `out_ready`=1 → DC rs 8'h03, value 5, length 3, is_dc=1; then EOB rs 8'h00, last=1. Exactly 2 symbols; `in_ready` never low.
- Follow with block [3, 0×63] → DC diff −2: rs 8'h02, value 1, length 2. Then assert `dc_predictor_reset` with next DC 3 → rs 8'h02, value 3.
- Block [0, 0×20, −1 at idx 21, 0×42] → DC rs 8'h00, length 0; then ZRL 8'hF0; then rs 8'h41, value 0, length 1; then EOB. `in_ready` low exactly one cycle.
- Block [0, 0×62, 7 at idx 63] → DC, then 3× 8'hF0, then rs 8'hE3, value 7, last=1. No EOB.
- `out_ready` held 0 for 10 cycles mid-block → outputs frozen, `in_ready`=0, no coefficients lost. Compare the full symbol stream against a software model.
- Assert `reset` asynchronously during a ZRL sequence → `out_valid` drops immediately. A fresh block [4, 0×63] yields rs 8'h03, value 4 (predictor 0).
